// File: rtl/irrigation_pkg.sv
// rtl/irrigation_pkg.sv - shared types and constants for the irrigation sequencer
package irrigation_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WATERING = 2'd1,
        ST_PAUSE    = 2'd2,
        ST_FAULT    = 2'd3
    } irr_state_t;

    localparam logic [5:0] SEC_MAX = 6'd59;
    localparam int         MIN_W   = 8;

endpackage

// File: rtl/irrigation_sequencer_timer_monitor.sv
// rtl/irrigation_sequencer_timer_monitor.sv - classifies countdown steps into ticks, resyncs and faults
module timer_monitor (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] seconds_counter,
    output logic       sec_tick,
    output logic       min_tick,
    output logic       proto_fault
);
    import irrigation_pkg::*;

    logic [5:0] prev;
    logic       is_dec;
    logic       is_wrap;
    logic       is_bad;

    // A jump back to 59 from anything but 0 is a silent resync, not a fault.
    always_comb begin
        is_dec  = 1'b0;
        is_wrap = 1'b0;
        is_bad  = 1'b0;
        if (seconds_counter > SEC_MAX) begin
            is_bad = 1'b1;
        end else if (seconds_counter != prev) begin
            if (prev != 6'd0 && seconds_counter == prev - 6'd1)
                is_dec = 1'b1;
            else if (prev == 6'd0 && seconds_counter == SEC_MAX)
                is_wrap = 1'b1;
            else if (seconds_counter != SEC_MAX)
                is_bad = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev        <= SEC_MAX;
            sec_tick    <= 1'b0;
            min_tick    <= 1'b0;
            proto_fault <= 1'b0;
        end else begin
            prev        <= seconds_counter;
            sec_tick    <= is_dec | is_wrap;
            min_tick    <= is_wrap;
            proto_fault <= is_bad;
        end
    end

endmodule

// File: rtl/irrigation_sequencer.sv
// rtl/irrigation_sequencer.sv - valve watering/rest sequencer driven by the seconds countdown
module irrigation_sequencer
    import irrigation_pkg::*;
#(
    parameter int WATER_MIN = 5,
    parameter int PAUSE_MIN = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       seconds_counter,
    input  logic             soil_dry,
    input  logic             manual_start,
    input  logic             manual_stop,
    output logic             valve,
    output logic [1:0]       state_out,
    output logic [MIN_W-1:0] minutes_left,
    output logic             sec_tick,
    output logic             fault
);

    localparam logic [MIN_W-1:0] WATER_LOAD = MIN_W'(WATER_MIN);
    localparam logic [MIN_W-1:0] PAUSE_LOAD = MIN_W'(PAUSE_MIN);
    localparam logic [MIN_W-1:0] ONE_MIN    = MIN_W'(1);

    logic       min_tick;
    logic       proto_fault;
    logic       dry_s1, dry_s2;
    logic       start_s1, start_s2, start_s3;
    logic       stop_s1, stop_s2;
    logic       start_edge;
    irr_state_t state;

    timer_monitor u_timer_monitor (
        .clk             (clk),
        .reset           (reset),
        .seconds_counter (seconds_counter),
        .sec_tick        (sec_tick),
        .min_tick        (min_tick),
        .proto_fault     (proto_fault)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dry_s1   <= 1'b0;
            dry_s2   <= 1'b0;
            start_s1 <= 1'b0;
            start_s2 <= 1'b0;
            start_s3 <= 1'b0;
            stop_s1  <= 1'b0;
            stop_s2  <= 1'b0;
        end else begin
            dry_s1   <= soil_dry;
            dry_s2   <= dry_s1;
            start_s1 <= manual_start;
            start_s2 <= start_s1;
            start_s3 <= start_s2;
            stop_s1  <= manual_stop;
            stop_s2  <= stop_s1;
        end
    end

    assign start_edge = start_s2 & ~start_s3;
    assign state_out  = state;

    // A protocol fault overrides every other event and is only cleared by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            valve        <= 1'b0;
            minutes_left <= '0;
            fault        <= 1'b0;
        end else if (proto_fault) begin
            state        <= ST_FAULT;
            valve        <= 1'b0;
            minutes_left <= '0;
            fault        <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if ((dry_s2 || start_edge) && !stop_s2) begin
                        state        <= ST_WATERING;
                        minutes_left <= WATER_LOAD;
                        valve        <= 1'b1;
                    end
                end
                ST_WATERING: begin
                    if (stop_s2 || (min_tick && minutes_left == ONE_MIN)) begin
                        state        <= ST_PAUSE;
                        minutes_left <= PAUSE_LOAD;
                        valve        <= 1'b0;
                    end else if (min_tick) begin
                        minutes_left <= minutes_left - ONE_MIN;
                    end
                end
                ST_PAUSE: begin
                    if (min_tick) begin
                        if (minutes_left == ONE_MIN) begin
                            state        <= ST_IDLE;
                            minutes_left <= '0;
                        end else begin
                            minutes_left <= minutes_left - ONE_MIN;
                        end
                    end
                end
                default: begin
                    state        <= ST_FAULT;
                    valve        <= 1'b0;
                    minutes_left <= '0;
                    fault        <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_irrigation_sequencer.sv
// tb/tb_irrigation_sequencer.sv - self-checking bench for irrigation_sequencer
module tb_irrigation_sequencer;

    localparam int WATER_MIN = 5;
    localparam int PAUSE_MIN = 10;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] seconds_counter = 6'd59;
    logic       soil_dry = 1'b0;
    logic       manual_start = 1'b0;
    logic       manual_stop = 1'b0;
    logic       valve;
    logic [1:0] state_out;
    logic [7:0] minutes_left;
    logic       sec_tick;
    logic       fault;

    int checks = 0;
    int failures = 0;
    int cur = 59;

    // Reference model: mode 0..3, minutes remaining, pending monitor results, input history
    int m_prev, m_mode, m_left;
    bit m_sec, m_min, m_pf;
    bit dry_h[3];
    bit st_h[3];
    bit sp_h[3];

    irrigation_sequencer #(.WATER_MIN(WATER_MIN), .PAUSE_MIN(PAUSE_MIN)) dut (
        .clk             (clk),
        .reset           (reset),
        .seconds_counter (seconds_counter),
        .soil_dry        (soil_dry),
        .manual_start    (manual_start),
        .manual_stop     (manual_stop),
        .valve           (valve),
        .state_out       (state_out),
        .minutes_left    (minutes_left),
        .sec_tick        (sec_tick),
        .fault           (fault)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic model_reset();
        m_prev = 59; m_mode = 0; m_left = 0;
        m_sec = 0; m_min = 0; m_pf = 0;
        for (int i = 0; i < 3; i++) begin
            dry_h[i] = 0; st_h[i] = 0; sp_h[i] = 0;
        end
    endtask

    task automatic model_edge();
        int n, p;
        if (m_pf) begin
            m_mode = 3; m_left = 0;
        end else if (m_mode == 0) begin
            if ((dry_h[1] || (st_h[1] && !st_h[2])) && !sp_h[1]) begin
                m_mode = 1; m_left = WATER_MIN;
            end
        end else if (m_mode == 1) begin
            if (sp_h[1]) begin
                m_mode = 2; m_left = PAUSE_MIN;
            end else if (m_min) begin
                m_left = m_left - 1;
                if (m_left == 0) begin m_mode = 2; m_left = PAUSE_MIN; end
            end
        end else if (m_mode == 2 && m_min) begin
            m_left = m_left - 1;
            if (m_left == 0) m_mode = 0;
        end
        n = int'(seconds_counter);
        p = m_prev;
        m_sec = 0; m_min = 0; m_pf = 0;
        if (n > 59) m_pf = 1;
        else if (n == p - 1) m_sec = 1;
        else if (p == 0 && n == 59) begin m_sec = 1; m_min = 1; end
        else if (n != p && n != 59) m_pf = 1;
        m_prev = n;
        dry_h[2] = dry_h[1]; dry_h[1] = dry_h[0]; dry_h[0] = soil_dry;
        st_h[2] = st_h[1];   st_h[1] = st_h[0];   st_h[0] = manual_start;
        sp_h[2] = sp_h[1];   sp_h[1] = sp_h[0];   sp_h[0] = manual_stop;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1; seconds_counter = 6'd59; cur = 59;
        soil_dry = 1'b0; manual_start = 1'b0; manual_stop = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    // One countdown second: value change followed by two held cycles
    task automatic tick_second();
        cur = (cur == 0) ? 59 : cur - 1;
        seconds_counter = 6'(cur);
        step(); step(); step();
    endtask

    task automatic run_wraps(input int n);
        int w = 0;
        while (w < n) begin
            tick_second();
            if (cur == 59) w++;
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (valve !== 1'b0) begin failures++; $display("FAIL reset_valve: got %b expected 0", valve); end
        checks++; if (state_out !== 2'd0) begin failures++; $display("FAIL reset_state: got %0d expected 0", state_out); end
        checks++; if (minutes_left !== 8'd0) begin failures++; $display("FAIL reset_minutes: got %0d expected 0", minutes_left); end
        checks++; if (sec_tick !== 1'b0) begin failures++; $display("FAIL reset_sec_tick: got %b expected 0", sec_tick); end
        checks++; if (fault !== 1'b0) begin failures++; $display("FAIL reset_fault: got %b expected 0", fault); end
        seconds_counter = 6'd58; cur = 58; step();
        checks++; if (sec_tick !== 1'b1) begin failures++; $display("FAIL reset_prev59_tick: got %b expected 1", sec_tick); end
        step();
        checks++; if (sec_tick !== 1'b0) begin failures++; $display("FAIL reset_hold_tick: got %b expected 0", sec_tick); end
        step();
        checks++; if (fault !== 1'b0) begin failures++; $display("FAIL reset_prev59_fault: got %b expected 0", fault); end
    endtask

    task automatic test_sensor_watering();
        do_reset();
        soil_dry = 1'b1;
        step(); step();
        checks++; if (valve !== 1'b0) begin failures++; $display("FAIL sensor_early_valve: got %b expected 0", valve); end
        step();
        checks++; if (valve !== 1'b1) begin failures++; $display("FAIL sensor_valve: got %b expected 1", valve); end
        checks++; if (state_out !== 2'd1) begin failures++; $display("FAIL sensor_state: got %0d expected 1", state_out); end
        checks++; if (minutes_left !== 8'd5) begin failures++; $display("FAIL sensor_minutes: got %0d expected 5", minutes_left); end
        soil_dry = 1'b0;
        run_wraps(4);
        checks++; if (minutes_left !== 8'd1) begin failures++; $display("FAIL sensor_last_minute: got %0d expected 1", minutes_left); end
        run_wraps(1);
        checks++; if (state_out !== 2'd2) begin failures++; $display("FAIL sensor_pause_state: got %0d expected 2", state_out); end
        checks++; if (minutes_left !== 8'd10) begin failures++; $display("FAIL sensor_pause_minutes: got %0d expected 10", minutes_left); end
        checks++; if (valve !== 1'b0) begin failures++; $display("FAIL sensor_pause_valve: got %b expected 0", valve); end
        run_wraps(10);
        checks++; if (state_out !== 2'd0) begin failures++; $display("FAIL sensor_idle_state: got %0d expected 0", state_out); end
        checks++; if (minutes_left !== 8'd0) begin failures++; $display("FAIL sensor_idle_minutes: got %0d expected 0", minutes_left); end
    endtask

    task automatic test_manual_stop();
        do_reset();
        manual_start = 1'b1; step();
        manual_start = 1'b0; step(); step();
        checks++; if (valve !== 1'b1) begin failures++; $display("FAIL manual_valve: got %b expected 1", valve); end
        run_wraps(1);
        checks++; if (minutes_left !== 8'd4) begin failures++; $display("FAIL manual_minutes: got %0d expected 4", minutes_left); end
        while (cur != 0) tick_second();
        cur = 59; seconds_counter = 6'd59; manual_stop = 1'b1;
        step(); step(); step();
        checks++; if (state_out !== 2'd2) begin failures++; $display("FAIL stop_prio_state: got %0d expected 2", state_out); end
        checks++; if (minutes_left !== 8'd10) begin failures++; $display("FAIL stop_prio_minutes: got %0d expected 10", minutes_left); end
        checks++; if (valve !== 1'b0) begin failures++; $display("FAIL stop_prio_valve: got %b expected 0", valve); end
        manual_stop = 1'b0;
    endtask

    task automatic test_simultaneous();
        do_reset();
        manual_start = 1'b1; manual_stop = 1'b1; step();
        manual_start = 1'b0; step(); step(); step();
        checks++; if (state_out !== 2'd0) begin failures++; $display("FAIL simul_state: got %0d expected 0", state_out); end
        checks++; if (valve !== 1'b0) begin failures++; $display("FAIL simul_valve: got %b expected 0", valve); end
        manual_stop = 1'b0; step(); step(); step();
        checks++; if (state_out !== 2'd0) begin failures++; $display("FAIL simul_after_state: got %0d expected 0", state_out); end
    endtask

    task automatic test_fault_jump();
        do_reset();
        soil_dry = 1'b1; step(); step(); step();
        checks++; if (valve !== 1'b1) begin failures++; $display("FAIL fault_pre_valve: got %b expected 1", valve); end
        seconds_counter = 6'd58; step();
        seconds_counter = 6'd40; cur = 40; step();
        checks++; if (fault !== 1'b0) begin failures++; $display("FAIL fault_early: got %b expected 0", fault); end
        step();
        checks++; if (fault !== 1'b1) begin failures++; $display("FAIL fault_flag: got %b expected 1", fault); end
        checks++; if (state_out !== 2'd3) begin failures++; $display("FAIL fault_state: got %0d expected 3", state_out); end
        checks++; if (valve !== 1'b0) begin failures++; $display("FAIL fault_valve: got %b expected 0", valve); end
        for (int i = 0; i < 10; i++) tick_second();
        checks++; if (fault !== 1'b1 || valve !== 1'b0) begin failures++; $display("FAIL fault_sticky: got fault=%b valve=%b expected 1/0", fault, valve); end
        checks++; if (minutes_left !== 8'd0) begin failures++; $display("FAIL fault_minutes: got %0d expected 0", minutes_left); end
        do_reset();
        checks++; if (fault !== 1'b0) begin failures++; $display("FAIL fault_clear: got %b expected 0", fault); end
        seconds_counter = 6'd63; step(); step();
        checks++; if (fault !== 1'b1) begin failures++; $display("FAIL fault_63: got %b expected 1", fault); end
        checks++; if (state_out !== 2'd3) begin failures++; $display("FAIL fault_63_state: got %0d expected 3", state_out); end
    endtask

    task automatic test_resync();
        int pulses = 0;
        do_reset();
        soil_dry = 1'b1; step(); step(); step();
        soil_dry = 1'b0;
        while (cur > 30) begin
            cur = cur - 1; seconds_counter = 6'(cur); step();
            checks++; if (sec_tick !== 1'b1) begin failures++; $display("FAIL resync_dec_tick at %0d: got %b expected 1", cur, sec_tick); end
            if (sec_tick === 1'b1) pulses++;
            repeat ($urandom_range(0, 2)) begin
                step();
                checks++; if (sec_tick !== 1'b0) begin failures++; $display("FAIL resync_hold_tick at %0d: got %b expected 0", cur, sec_tick); end
            end
        end
        cur = 59; seconds_counter = 6'd59; step();
        checks++; if (sec_tick !== 1'b0) begin failures++; $display("FAIL resync_jump_tick: got %b expected 0", sec_tick); end
        step(); step();
        checks++; if (pulses != 29) begin failures++; $display("FAIL resync_pulse_count: got %0d expected 29", pulses); end
        checks++; if (fault !== 1'b0) begin failures++; $display("FAIL resync_fault: got %b expected 0", fault); end
        checks++; if (minutes_left !== 8'd5 || state_out !== 2'd1) begin failures++; $display("FAIL resync_minute: got min=%0d state=%0d expected 5/1", minutes_left, state_out); end
    endtask

    task automatic test_reset_mid_watering();
        do_reset();
        soil_dry = 1'b1; step(); step(); step();
        checks++; if (valve !== 1'b1) begin failures++; $display("FAIL midrst_pre_valve: got %b expected 1", valve); end
        #2 reset = 1'b1;
        #1;
        checks++; if (valve !== 1'b0) begin failures++; $display("FAIL midrst_valve: got %b expected 0", valve); end
        checks++; if (state_out !== 2'd0 || minutes_left !== 8'd0) begin failures++; $display("FAIL midrst_state: got state=%0d min=%0d expected 0/0", state_out, minutes_left); end
        checks++; if (fault !== 1'b0 || sec_tick !== 1'b0) begin failures++; $display("FAIL midrst_flags: got fault=%b tick=%b expected 0/0", fault, sec_tick); end
        @(negedge clk);
        soil_dry = 1'b0; reset = 1'b0; seconds_counter = 6'd59; cur = 59;
        model_reset();
    endtask

    task automatic test_random();
        for (int ep = 0; ep < 4; ep++) begin
            do_reset();
            for (int c = 0; c < 3000; c++) begin
                int r;
                r = $urandom_range(0, 999);
                if (r >= 450 && r < 980) cur = (cur == 0) ? 59 : cur - 1;
                else if (r >= 980 && r < 995) cur = 59;
                else if (r >= 995 && ep >= 2) cur = $urandom_range(0, 63);
                seconds_counter = 6'(cur);
                if ($urandom_range(0, 199) == 0) soil_dry = ~soil_dry;
                manual_start = ($urandom_range(0, 99) == 0);
                if ($urandom_range(0, 149) == 0) manual_stop = ~manual_stop;
                step();
                checks++; if (valve !== (m_mode == 1)) begin failures++; $display("FAIL rand_valve ep%0d c%0d: got %b expected %b", ep, c, valve, m_mode == 1); end
                checks++; if (state_out !== 2'(m_mode)) begin failures++; $display("FAIL rand_state ep%0d c%0d: got %0d expected %0d", ep, c, state_out, m_mode); end
                checks++; if (minutes_left !== 8'(m_left)) begin failures++; $display("FAIL rand_minutes ep%0d c%0d: got %0d expected %0d", ep, c, minutes_left, m_left); end
                checks++; if (sec_tick !== m_sec) begin failures++; $display("FAIL rand_sec_tick ep%0d c%0d: got %b expected %b", ep, c, sec_tick, m_sec); end
                checks++; if (fault !== (m_mode == 3)) begin failures++; $display("FAIL rand_fault ep%0d c%0d: got %b expected %b", ep, c, fault, m_mode == 3); end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_sensor_watering();
        test_manual_stop();
        test_simultaneous();
        test_fault_jump();
        test_resync();
        test_reset_mid_watering();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
